// File: rtl/grid_mover.sv
// Moves a single cell across a GRID_W x GRID_H grid at a fixed step rate,
// steering from keyboard direction codes and handling edges by wrap or stop.
module grid_mover #(
  parameter int GRID_W      = 40,
  parameter int GRID_H      = 30,
  parameter int X_W         = 6,
  parameter int Y_W         = 5,
  parameter int STEP_CYCLES = 12500000,
  parameter int WRAP        = 1,
  parameter int START_X     = 20,
  parameter int START_Y     = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     move,
  input  logic           move_valid,
  input  logic           enable,
  input  logic           restart,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic [1:0]     dir,
  output logic           step_pulse,
  output logic           hit_wall,
  output logic           moving
);

  localparam int CNT_W = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       pend;
  logic             step;
  logic             blocked;
  logic [X_W-1:0]   nx;
  logic [Y_W-1:0]   ny;

  // Same axis (bit 1), opposite sense (bit 0) is a 180-degree turn.
  function automatic logic is_rev(input logic [1:0] a, input logic [1:0] b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

  assign step = (state == RUN) && enable && (cnt == CNT_W'(STEP_CYCLES - 1));

  // Next cell from the pending heading; edges compared explicitly.
  always_comb begin
    nx      = pos_x;
    ny      = pos_y;
    blocked = 1'b0;
    case (pend)
      2'b00: if (pos_y == '0) begin
               if (WRAP != 0) ny = Y_W'(GRID_H - 1); else blocked = 1'b1;
             end else ny = pos_y - Y_W'(1);
      2'b01: if (pos_y == Y_W'(GRID_H - 1)) begin
               if (WRAP != 0) ny = '0; else blocked = 1'b1;
             end else ny = pos_y + Y_W'(1);
      2'b10: if (pos_x == '0) begin
               if (WRAP != 0) nx = X_W'(GRID_W - 1); else blocked = 1'b1;
             end else nx = pos_x - X_W'(1);
      default: if (pos_x == X_W'(GRID_W - 1)) begin
                 if (WRAP != 0) nx = '0; else blocked = 1'b1;
               end else nx = pos_x + X_W'(1);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      pend       <= 2'b00;
      pos_x      <= X_W'(START_X);
      pos_y      <= Y_W'(START_Y);
      dir        <= 2'b00;
      step_pulse <= 1'b0;
      hit_wall   <= 1'b0;
      moving     <= 1'b0;
    end else if (restart) begin
      state      <= IDLE;
      cnt        <= '0;
      pend       <= 2'b00;
      pos_x      <= X_W'(START_X);
      pos_y      <= Y_W'(START_Y);
      dir        <= 2'b00;
      step_pulse <= 1'b0;
      hit_wall   <= 1'b0;
      moving     <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      case (state)
        IDLE: if (move_valid) begin
          pend   <= move;
          cnt    <= '0;
          state  <= RUN;
          moving <= 1'b1;
        end
        RUN: begin
          if (enable) cnt <= step ? '0 : cnt + CNT_W'(1);
          if (step) begin
            dir <= pend;
            if (blocked) begin
              hit_wall <= 1'b1;
              moving   <= 1'b0;
              state    <= STOP;
            end else begin
              pos_x      <= nx;
              pos_y      <= ny;
              step_pulse <= 1'b1;
            end
          end
          // A move arriving on the step edge is judged against the heading
          // being committed on that edge and lands at the next step.
          if (move_valid && !is_rev(move, step ? pend : dir)) pend <= move;
        end
        STOP: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_mover.sv
// Directed bench: three grid_mover instances share stimulus; each covers
// normal stepping, wrap-around, or wall stop.
module tb_grid_mover;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] move;
  logic       move_valid, enable, restart;

  logic [5:0] a_x, b_x, c_x;
  logic [4:0] a_y, b_y, c_y;
  logic [1:0] a_dir, b_dir, c_dir;
  logic       a_sp, b_sp, c_sp, a_hw, b_hw, c_hw, a_mv, b_mv, c_mv;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  grid_mover #(.STEP_CYCLES(4), .WRAP(1), .START_X(20), .START_Y(15)) u_a (
    .clk(clk), .rst_n(rst_n), .move(move), .move_valid(move_valid),
    .enable(enable), .restart(restart), .pos_x(a_x), .pos_y(a_y),
    .dir(a_dir), .step_pulse(a_sp), .hit_wall(a_hw), .moving(a_mv));

  grid_mover #(.STEP_CYCLES(4), .WRAP(1), .START_X(39), .START_Y(0)) u_b (
    .clk(clk), .rst_n(rst_n), .move(move), .move_valid(move_valid),
    .enable(enable), .restart(restart), .pos_x(b_x), .pos_y(b_y),
    .dir(b_dir), .step_pulse(b_sp), .hit_wall(b_hw), .moving(b_mv));

  grid_mover #(.STEP_CYCLES(4), .WRAP(0), .START_X(38), .START_Y(15)) u_c (
    .clk(clk), .rst_n(rst_n), .move(move), .move_valid(move_valid),
    .enable(enable), .restart(restart), .pos_x(c_x), .pos_y(c_y),
    .dir(c_dir), .step_pulse(c_sp), .hit_wall(c_hw), .moving(c_mv));

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [1:0] m);
    move       = m;
    move_valid = 1'b1;
    tick(1);
    move_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; move = 2'b00; move_valid = 1'b0; enable = 1'b0; restart = 1'b0;
    tick(2);
    chk("rst_x", a_x, 20);   chk("rst_y", a_y, 15);  chk("rst_dir", a_dir, 0);
    chk("rst_sp", a_sp, 0);  chk("rst_hw", a_hw, 0); chk("rst_mv", a_mv, 0);
    rst_n = 1'b1;
    tick(1);

    // Basic right move, 4-cycle step period
    enable = 1'b1;
    strobe(2'b11);
    chk("run_mv", a_mv, 1);
    tick(3);
    chk("pre_step_x", a_x, 20); chk("pre_step_sp", a_sp, 0);
    tick(1);
    chk("step1_x", a_x, 21); chk("step1_y", a_y, 15);
    chk("step1_sp", a_sp, 1); chk("step1_dir", a_dir, 3);
    chk("wrap_right_x", b_x, 0);
    chk("wall_first_x", c_x, 39); chk("wall_first_sp", c_sp, 1);
    tick(1);
    chk("sp_one_cycle", a_sp, 0);
    tick(3);
    chk("step2_x", a_x, 22); chk("step2_sp", a_sp, 1); chk("step2_mv", a_mv, 1);
    chk("wall_x", c_x, 39); chk("wall_hw", c_hw, 1);
    chk("wall_mv", c_mv, 0); chk("wall_sp", c_sp, 0);

    // Reversal rejected; STOP ignores strobes
    strobe(2'b10);
    chk("stop_dir", c_dir, 3); chk("stop_x", c_x, 39);
    tick(3);
    chk("rev_x", a_x, 23); chk("rev_dir", a_dir, 3);

    // Turn up; u_b wraps from row 0
    strobe(2'b00);
    tick(3);
    chk("up_y", a_y, 14); chk("up_dir", a_dir, 0); chk("up_x", a_x, 23);
    chk("wrap_up_y", b_y, 29); chk("wrap_up_x", b_x, 2);

    // Pause 10 cycles mid-count, with a move latched while paused
    tick(2);
    enable = 1'b0;
    strobe(2'b10);
    tick(9);
    chk("pause_y", a_y, 14); chk("pause_x", a_x, 23);
    enable = 1'b1;
    tick(1);
    chk("late_pre_x", a_x, 23); chk("late_pre_sp", a_sp, 0);
    tick(1);
    chk("late_x", a_x, 22); chk("late_y", a_y, 14);
    chk("late_dir", a_dir, 2); chk("late_sp", a_sp, 1);

    // Move on the step edge applies at the following step
    tick(3);
    strobe(2'b00);
    chk("coinc_x", a_x, 21); chk("coinc_dir", a_dir, 2);
    tick(4);
    chk("coinc_next_x", a_x, 21); chk("coinc_next_y", a_y, 13);
    chk("coinc_next_dir", a_dir, 0);

    // Synchronous restart
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    chk("rs_x", c_x, 38); chk("rs_y", c_y, 15); chk("rs_hw", c_hw, 0);
    chk("rs_mv", c_mv, 0); chk("rs_dir", c_dir, 0);
    chk("rs_a_x", a_x, 20); chk("rs_a_mv", a_mv, 0);

    // First move accepted while paused; counting waits for enable
    enable = 1'b0;
    strobe(2'b01);
    chk("idle_pause_mv", a_mv, 1);
    tick(6);
    chk("idle_pause_y", a_y, 15);
    enable = 1'b1;
    tick(4);
    chk("down_y", a_y, 16); chk("down_sp", a_sp, 1);

    // Asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_y", a_y, 15); chk("async_mv", a_mv, 0);
    chk("async_dir", a_dir, 0); chk("async_sp", a_sp, 0);
    #1;
    rst_n = 1'b1;
    tick(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
